// File: rtl/pixel_stream_tx_if.sv
// rtl/pixel_stream_tx_if.sv - frame request, pixel-memory read and framed pixel output bundle
interface pixel_stream_tx_if #(
   parameter int data_width = 16,
   parameter int addr_width = 9
);
   logic                  start;
   logic                  rd_en;
   logic [addr_width-1:0] rd_addr;
   logic [data_width-1:0] rd_data;
   logic                  HSYNC;
   logic                  VSYNC;
   logic [data_width-1:0] data_out;
   logic                  busy;
   logic                  done_out;

   modport master (
      input  start, rd_data,
      output rd_en, rd_addr, HSYNC, VSYNC, data_out, busy, done_out
   );

   modport slave (
      output start, rd_data,
      input  rd_en, rd_addr, HSYNC, VSYNC, data_out, busy, done_out
   );
endinterface

// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - reads one frame from pixel memory and emits it VSYNC/HSYNC framed
module pixel_stream_tx #(
   parameter int image_width  = 18,
   parameter int image_height = 18,
   parameter int data_width   = 16,
   parameter int addr_width   = 9,
   parameter int h_blank      = 4,
   parameter int v_front      = 2,
   parameter int v_back       = 2
) (
   input  logic               clk,
   input  logic               rst,
   pixel_stream_tx_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VFRONT,
      S_ACTIVE,
      S_HBLANK,
      S_VBACK
   } state_t;

   localparam int CW = 16;
   localparam logic [CW-1:0] VF_LAST   = CW'(v_front - 1);
   localparam logic [CW-1:0] W_LAST    = CW'(image_width - 1);
   localparam logic [CW-1:0] HB_LAST   = CW'(h_blank - 1);
   localparam logic [CW-1:0] VB_LAST   = CW'(v_back - 1);
   localparam logic [CW-1:0] LINE_LAST = CW'(image_height - 1);

   state_t                r_state, w_state_next;
   logic [CW-1:0]         r_cnt, w_cnt_next;
   logic [CW-1:0]         r_line, w_line_next;
   logic [addr_width-1:0] r_rd_addr, w_rd_addr_next;
   logic                  r_rd_en;
   logic                  r_vs_int;
   logic                  r_hs_d1, r_vs_d1;
   logic                  r_hsync, r_vsync;
   logic [data_width-1:0] r_data_out;
   logic                  r_busy, r_done;

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt + CW'(1);
      w_line_next    = r_line;
      w_rd_addr_next = r_rd_addr;
      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            if (bus.start) begin
               w_state_next   = S_VFRONT;
               w_line_next    = '0;
               w_rd_addr_next = '0;
            end
         end
         S_VFRONT: begin
            if (r_cnt == VF_LAST) begin
               w_state_next = S_ACTIVE;
               w_cnt_next   = '0;
            end
         end
         S_ACTIVE: begin
            w_rd_addr_next = r_rd_addr + addr_width'(1);
            if (r_cnt == W_LAST) begin
               w_state_next = S_HBLANK;
               w_cnt_next   = '0;
            end
         end
         S_HBLANK: begin
            if (r_cnt == HB_LAST) begin
               w_cnt_next = '0;
               if (r_line == LINE_LAST) begin
                  w_state_next = S_VBACK;
               end else begin
                  w_state_next = S_ACTIVE;
                  w_line_next  = r_line + CW'(1);
               end
            end
         end
         S_VBACK: begin
            if (r_cnt == VB_LAST) begin
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Two-stage delay on the syncs matches the one-cycle memory latency plus the data_out register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_line     <= '0;
         r_rd_addr  <= '0;
         r_rd_en    <= 1'b0;
         r_vs_int   <= 1'b0;
         r_hs_d1    <= 1'b0;
         r_vs_d1    <= 1'b0;
         r_hsync    <= 1'b0;
         r_vsync    <= 1'b0;
         r_data_out <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_line     <= w_line_next;
         r_rd_addr  <= w_rd_addr_next;
         r_rd_en    <= (w_state_next == S_ACTIVE);
         r_vs_int   <= (w_state_next != S_IDLE);
         r_hs_d1    <= r_rd_en;
         r_hsync    <= r_hs_d1;
         r_vs_d1    <= r_vs_int;
         r_vsync    <= r_vs_d1;
         r_data_out <= bus.rd_data;
         r_done     <= r_vsync & ~r_vs_d1;
         // Stays high across a back-to-back restart so the one-cycle VSYNC gap does not drop busy.
         r_busy     <= (w_state_next != S_IDLE) | r_vs_int | r_vs_d1;
      end
   end

   assign bus.rd_en    = r_rd_en;
   assign bus.rd_addr  = r_rd_addr;
   assign bus.HSYNC    = r_hsync;
   assign bus.VSYNC    = r_vsync;
   assign bus.data_out = r_data_out;
   assign bus.busy     = r_busy;
   assign bus.done_out = r_done;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb/tb_pixel_stream_tx.sv - scoreboard bench for pixel_stream_tx, default and small configurations
module tb_pixel_stream_tx;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pixel_stream_tx_if #(.data_width(16), .addr_width(9)) bus ();
   pixel_stream_tx_if #(.data_width(16), .addr_width(3)) sbus ();

   pixel_stream_tx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pixel_stream_tx #(
      .image_width (3),
      .image_height(2),
      .data_width  (16),
      .addr_width  (3),
      .h_blank     (1),
      .v_front     (1),
      .v_back      (1)
   ) u_small (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   // Pixel memories: word = address (small config: address + 100), one-cycle read latency.
   always @(posedge clk) if (bus.rd_en)  bus.rd_data  <= 16'(bus.rd_addr);
   always @(posedge clk) if (sbus.rd_en) sbus.rd_data <= 16'(sbus.rd_addr) + 16'd100;

   int          checks   = 0;
   int          failures = 0;
   int          done_cnt = 0;
   bit          armed    = 1'b0;
   bit          b2b      = 1'b0;
   logic [15:0] sb[$];
   logic [15:0] sb_exp;

   int          vs_len, hs_len, lo_len, npulse;
   bit          prev_vs, prev_hs, en_d1, en_d2;
   logic [8:0]  a_d1, a_d2;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int out_vec();
      return int'({bus.rd_en, bus.HSYNC, bus.VSYNC, bus.busy, bus.done_out,
                   (bus.rd_addr != 0), (bus.data_out != 0)});
   endfunction

   always @(negedge clk) begin
      if (armed) begin
         if (rst) begin
            chk(out_vec() == 0, "reset_outputs", out_vec(), 0);
            sb.delete();
            prev_vs = 0; prev_hs = 0; en_d1 = 0; en_d2 = 0; a_d1 = '0; a_d2 = '0;
            vs_len = 0; hs_len = 0; lo_len = 0; npulse = 0;
         end else begin
            chk(bus.HSYNC == en_d2, "hs_align", int'(bus.HSYNC), int'(en_d2));
            if (bus.HSYNC) begin
               chk(bus.data_out == 16'(a_d2), "data_align", int'(bus.data_out), int'(a_d2));
               if (sb.size() == 0) begin
                  chk(1'b0, "sb_underflow", int'(bus.data_out), -1);
               end else begin
                  sb_exp = sb.pop_front();
                  chk(bus.data_out == sb_exp, "sb_data", int'(bus.data_out), int'(sb_exp));
               end
            end
            if (bus.rd_en) chk(bus.rd_addr <= 9'd323, "addr_range", int'(bus.rd_addr), 323);
            chk(bus.done_out == (prev_vs && !bus.VSYNC), "done_pulse",
                int'(bus.done_out), int'(prev_vs && !bus.VSYNC));
            if (bus.VSYNC) chk(bus.busy, "busy_in_frame", int'(bus.busy), 1);
            if (bus.done_out) begin
               done_cnt++;
               if (b2b) b2b = 1'b0;
               else     chk(!bus.busy, "busy_fall", int'(bus.busy), 0);
            end
            if (bus.VSYNC) begin
               vs_len++;
               if (bus.HSYNC) begin
                  if (!prev_hs) begin
                     chk(lo_len == (npulse == 0 ? 2 : 4), "hs_gap", lo_len, (npulse == 0 ? 2 : 4));
                     npulse++;
                     hs_len = 0;
                  end
                  hs_len++;
                  lo_len = 0;
               end else begin
                  if (prev_hs) chk(hs_len == 18, "hs_width", hs_len, 18);
                  lo_len++;
               end
            end else begin
               chk(!bus.HSYNC, "hs_outside_frame", int'(bus.HSYNC), 0);
               if (prev_vs) begin
                  chk(vs_len == 400, "frame_len", vs_len, 400);
                  chk(npulse == 18, "hs_pulses", npulse, 18);
                  chk(lo_len == 6, "tail_blank", lo_len, 6);
               end
               vs_len = 0; npulse = 0; lo_len = 0; hs_len = 0;
            end
            prev_vs = bus.VSYNC; prev_hs = bus.HSYNC;
            en_d2 = en_d1; en_d1 = bus.rd_en;
            a_d2 = a_d1;   a_d1 = bus.rd_addr;
         end
      end
   end

   task automatic push_frame();
      for (int i = 0; i < 324; i++) sb.push_back(16'(i));
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk(done_cnt >= target, "frame_timeout", done_cnt, target);
      repeat (3) @(negedge clk);
      chk(done_cnt == target, "done_count", done_cnt, target);
      chk(sb.size() == 0, "sb_drained", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] pat;
      int         n;
      int         k;
      bus.start = 1'b0; sbus.start = 1'b0;
      bus.rd_data = '0; sbus.rd_data = '0;

      #23 rst = 1'b1;
      #1 chk(out_vec() == 0, "reset_async", out_vec(), 0);
      armed = 1'b1;
      bus.start = 1'b1; sbus.start = 1'b1;
      repeat (5) @(negedge clk);
      bus.start = 1'b0; sbus.start = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk(bus.VSYNC == 0 && bus.busy == 0, "idle_after_reset", int'({bus.VSYNC, bus.busy}), 0);

      push_frame();
      pulse_start();
      wait_done(1, 600);

      push_frame();
      pulse_start();
      repeat (99) @(negedge clk);
      pulse_start();
      wait_done(2, 600);

      push_frame();
      push_frame();
      b2b = 1'b1;
      bus.start = 1'b1;
      n = 0;
      while (done_cnt < 3 && n < 600) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      bus.start = 1'b0;
      chk(done_cnt == 3, "b2b_first_done", done_cnt, 3);
      wait_done(4, 600);

      push_frame();
      pulse_start();
      n = 0;
      while (!(bus.rd_en && bus.rd_addr == 9'd90) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(bus.rd_en && bus.rd_addr == 9'd90, "reach_line5", int'(bus.rd_addr), 90);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk({bus.VSYNC, bus.HSYNC, bus.done_out, bus.busy} == 4'b0000, "reset_midframe",
             int'({bus.VSYNC, bus.HSYNC, bus.done_out, bus.busy}), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk(done_cnt == 4, "no_done_on_reset", done_cnt, 4);
      push_frame();
      pulse_start();
      wait_done(5, 600);

      pat = 10'b0111011100;
      sbus.start = 1'b1;
      @(negedge clk);
      sbus.start = 1'b0;
      n = 0;
      while (!sbus.VSYNC && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk(sbus.VSYNC, "small_vs_rise", int'(sbus.VSYNC), 1);
      k = 0;
      for (int i = 0; i < 10; i++) begin
         chk(sbus.VSYNC, "small_vs_len", i, 10);
         chk(sbus.HSYNC == pat[9-i], "small_hs_pat", int'(sbus.HSYNC), int'(pat[9-i]));
         if (sbus.HSYNC) begin
            chk(sbus.data_out == 16'(100 + k), "small_data", int'(sbus.data_out), 100 + k);
            k++;
         end
         @(negedge clk);
      end
      chk(!sbus.VSYNC, "small_vs_fall", int'(sbus.VSYNC), 0);
      chk(sbus.done_out, "small_done", int'(sbus.done_out), 1);
      chk(!sbus.busy, "small_busy_fall", int'(sbus.busy), 0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pixel_stream_tx.md
Name: pixel_stream_tx

Overview:
- Frame transmitter for the pixel-stream interface: reads one frame from a pixel memory and emits it as VSYNC/HSYNC-framed data.
- Drives the receiving pixel-stream blocks from test/frame storage, e.g. for loopback and self-test of the neural-net input path.
- Protocol: VSYNC high for the whole frame; HSYNC high exactly on valid-pixel cycles; data valid when HSYNC=1; HSYNC=0 inside the frame means pause/blank.

Parameters:
- image_width, 18, pixels per line (>=1)
- image_height, 18, lines per frame (>=1)
- data_width, 16, pixel width in bits
- addr_width, 9, pixel-memory address width; must satisfy 2^addr_width >= image_width*image_height
- h_blank, 4, HSYNC-low cycles after every line, including the last (>=1)
- v_front, 2, VSYNC-high/HSYNC-low cycles before the first line (>=1)
- v_back, 2, VSYNC-high/HSYNC-low cycles after the last line's blank (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- rd_en  out  1  pixel memory read enable
- rd_addr  out  addr_width  pixel address, row-major: row*image_width+col
- rd_data  in  data_width  memory data, valid exactly 1 cycle after rd_en/rd_addr
- HSYNC  out  1  line-active / pixel-valid
- VSYNC  out  1  frame-active
- data_out  out  data_width  pixel data, meaningful only when HSYNC=1
- busy  out  1  frame in progress
- done_out  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset (async assert, sync release): state=IDLE; all counters 0; rd_en=0, rd_addr=0, HSYNC=0, VSYNC=0, data_out=0, busy=0, done_out=0. Alignment pipeline also cleared.
- All outputs are registered.
- FSM states: IDLE, VFRONT, ACTIVE, HBLANK, VBACK.
- IDLE: on start=1, go to VFRONT and set busy=1 on the same edge. start in any other state is ignored, with no queuing.
- VFRONT: lasts v_front cycles, then ACTIVE.
- ACTIVE: lasts image_width cycles. rd_en=1 every cycle; rd_addr increments by 1 per cycle starting from 0 at frame start. Then HBLANK.
- HBLANK: lasts h_blank cycles. After it, go to ACTIVE if the line counter < image_height-1 (line counter increments); else go to VBACK.
- VBACK: lasts v_back cycles, then IDLE.
- Internal vs_int=1 in VFRONT/ACTIVE/HBLANK/VBACK; hs_int=1 only in ACTIVE; rd_en equals hs_int in the same cycle.
- Output alignment: HSYNC, VSYNC are hs_int, vs_int delayed 2 cycles. data_out is rd_data registered, so HSYNC=1 in cycle c iff rd_en=1 in cycle c-2, and data_out then holds the word addressed in cycle c-2.
- Frame length: VSYNC high for exactly v_front + image_height*(image_width+h_blank) + v_back consecutive cycles; defaults give 2+18*22+2 = 400.
- HSYNC pulses: image_height pulses of exactly image_width cycles each.
- done_out: 1 for exactly one cycle, in the first cycle VSYNC is 0 after a frame.
- busy: falls in that same cycle.
- Back-to-back frames: start held high re-enters VFRONT from IDLE; VSYNC output is low for >=1 cycle between frames.
- rd_addr: resets to 0 at each frame start; never exceeds image_width*image_height-1 while rd_en=1.
- Reset mid-frame: VSYNC/HSYNC drop immediately, no done_out pulse; the next start begins a full frame from address 0.
- Start latency: start sampled at edge e0 gives rd_en/VSYNC internal effect from e0. VSYNC output rises after edge e0+2.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; hold 5 cycles with start=1 -> outputs stay 0.
- Single frame, defaults, memory word = address: pulse start -> VSYNC high 400 cycles; 18 HSYNC pulses of 18 cycles separated by 4 low cycles; 2 low cycles before first and after last blank. data_out sequence 0..323 on HSYNC=1 cycles; done_out one pulse when VSYNC falls; busy matches.
- Alignment: check every cycle that HSYNC(c)==rd_en(c-2) and data_out(c)==mem[rd_addr(c-2)]; rd_addr never exceeds 323.
- Start ignored mid-frame: pulse start at cycle 100 of frame -> frame length still 400, exactly one done_out.
- Back-to-back: hold start high for 2 frames -> two 400-cycle VSYNC windows with >=1 low cycle between; each frame data 0..323; two done_out pulses.
- Reset mid-frame at line 5 -> VSYNC/HSYNC low at once, no done_out; a following start gives a full correct frame starting at address 0.
- Small config (image_width=3, image_height=2, h_blank=1, v_front=1, v_back=1) -> VSYNC high 1+2*4+1=10 cycles; HSYNC pattern 0,1,1,1,0,1,1,1,0,0.
